// File: rtl/muldiv_sequencer_if.sv
// Command/result bundle between the execute stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wr_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wr_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO register pair.
// Optional MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are all zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;   // product, or {remainder, quotient}
    logic [2*WIDTH-1:0] opa_q, opa_d;   // shifted multiplicand, or divisor
    logic [WIDTH-1:0]   opb_q, opb_d;   // multiplier bits not yet consumed
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div_by_zero_q, div_by_zero_d;

    logic is_div, is_signed;
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    // opa_q/opb_q still hold the raw operands while in PREP
    logic [WIDTH-1:0] abs_a, abs_b;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        abs_a = opa_q[WIDTH-1:0];
        abs_b = opb_q;
        if (is_signed && opa_q[WIDTH-1]) abs_a = -opa_q[WIDTH-1:0];
        if (is_signed && opb_q[WIDTH-1]) abs_b = -opb_q;
    end

    // One radix-2 iteration; PREP performs the first one on the fresh magnitudes
    logic [2*WIDTH-1:0] in_acc, in_opa, step_acc, step_opa;
    logic [WIDTH-1:0]   in_opb, step_opb;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [CW-1:0]      cnt_next;
    logic               last_iter;

    always_comb begin
        in_acc   = acc_q;
        in_opa   = opa_q;
        in_opb   = opb_q;
        cnt_next = cnt_q - CW'(1);
        if (state_q == S_PREP) begin
            in_acc   = is_div ? {{WIDTH{1'b0}}, abs_a} : '0;
            in_opa   = {{WIDTH{1'b0}}, (is_div ? abs_b : abs_a)};
            in_opb   = abs_b;
            cnt_next = CW'(WIDTH - 1);
        end
        div_shift = in_acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, in_opa[WIDTH-1:0]};
        if (is_div) begin
            step_acc = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        in_acc[WIDTH-2:0], ~div_diff[WIDTH]};
            step_opa = in_opa;
        end else begin
            step_acc = in_acc + (in_opb[0] ? in_opa : '0);
            step_opa = in_opa << 1;
        end
        step_opb  = in_opb >> 1;
        last_iter = (cnt_next == '0) || (EARLY_OUT && !is_div && (step_opb == '0));
    end

    // Sign correction applied on the way into HI/LO
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            fix_lo = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            fix_hi = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        acc_d         = acc_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d          = bus.op;
                    opa_d         = {{WIDTH{1'b0}}, bus.src_a};
                    opb_d         = bus.src_b;
                    div_by_zero_d = 1'b0;
                    state_d       = S_PREP;
                end else begin
                    if (bus.hi_we) hi_d = bus.wr_data;
                    if (bus.lo_we) lo_d = bus.wr_data;
                end
            end
            S_PREP: begin
                sign_a_d = is_signed & opa_q[WIDTH-1];
                sign_b_d = is_signed & opb_q[WIDTH-1];
                if (is_div && (opb_q == '0)) begin
                    div_by_zero_d = 1'b1;
                    hi_d          = opa_q[WIDTH-1:0];
                    lo_d          = '1;
                    state_d       = S_DONE;
                end else begin
                    acc_d   = step_acc;
                    opa_d   = step_opa;
                    opb_d   = step_opb;
                    cnt_d   = cnt_next;
                    state_d = last_iter ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                acc_d   = step_acc;
                opa_d   = step_opa;
                opb_d   = step_opb;
                cnt_d   = cnt_next;
                state_d = last_iter ? S_FIX : S_CALC;
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state uses non-blocking assignments only; every flop, datapath included, clears on reset.
        if (!reset) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            acc_q         <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            acc_q         <= acc_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.
- Sits beside the execute stage and is fed by decode-stage operands (alu_data_1 / reg_data_2).
- Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO, runs a radix-2 iterative FSM, and raises busy so the core stalls HI/LO consumers until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  multiplicand / dividend (rs value)
- src_b  in  WIDTH  multiplier / divisor (rt value)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wr_data  in  WIDTH  MTHI/MTLO data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when HI/LO hold a new result
- div_by_zero  out  1  sticky; set by a DIV/DIVU with src_b==0, cleared by next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset==0, any time, including mid-operation): state=IDLE; hi, lo = 0; busy, done, div_by_zero = 0; in-flight operation abandoned.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE, start==1: latch op and operands, clear div_by_zero, go to PREP.
- PREP:
  - signed ops take absolute values of both operands and record the sign bits; load the iteration counter with WIDTH.
  - divide with src_b==0: set div_by_zero, go directly to DONE.
  - otherwise go to CALC.
- CALC:
  - one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - counter decrements each cycle; at 0 go to FIX.
- FIX:
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
- DONE:
  - hi/lo are written on the edge entering DONE; done=1 for exactly this cycle.
  - next edge returns to IDLE. busy is high through DONE.
- Result mapping:
  - multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - divide: lo = quotient, hi = remainder.
- Divide by zero: hi = src_a, lo = all ones.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Latency, counted in rising edges after the edge that samples start:
  - done is high after edge WIDTH+2 (34 at default width).
  - divide by zero: done is high after edge 2.
- start while busy: ignored, no state change.
- hi_we/lo_we:
  - in IDLE with start==0: the register is written on the next edge; both strobes may be asserted together.
  - while busy: the write is dropped.
  - together with start in IDLE: start wins and the write is dropped.
- Operand/op inputs are don't-care after the start edge (internally latched).

Optional Feature:
- MULDIV_EARLY_OUT_EN
- Defined:
  - multiply CALC exits to FIX after the iteration that leaves the remaining (absolute) multiplier bits all zero; minimum 1 CALC cycle.
  - multiply latency becomes 2+N, where N is the index of the highest set bit of |src_b| plus 1, and N=1 when |src_b|=0.
  - divide is unchanged.
- Undefined: fixed WIDTH CALC cycles for all ops.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done after edge 34, hi=0xFFFFFFFE, lo=0x00000001, busy high for edges 1..34.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; with MULDIV_EARLY_OUT_EN, done after edge 5.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> done after edge 2, hi=7, lo=0xFFFFFFFF, div_by_zero=1, cleared by next start.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- MTHI 0x1234 in IDLE -> hi=0x1234 next edge; hi_we during busy and hi_we with start -> hi unchanged until the result is committed; start pulsed mid-CALC -> ignored, original result delivered.
- reset driven low at edge 10 of a MULTU -> busy, done, hi, lo = 0 immediately (asynchronous); after release a new start completes normally.
